sram_wb_bridge: RTL
===================

# sram_wb_bridge

Wishbone classic slave that fronts one 32x256 1RW1R OpenRAM macro and drives its RW port (port 0) from the user-project Wishbone bus. Sequences the macro's registered-input / negedge-output protocol: registers all macro pins, captures read data, and returns ack (or err) to the master. Port 1 is parked idle by this block; it is left for a future streaming reader.

## Interface
- BASE_ADDR, 32'h3000_0000: byte base address of the 1 KiB window.
- ADDR_WIDTH, 8: macro word-address width; window size is 4 << ADDR_WIDTH bytes.
- DATA_WIDTH, 32: macro and bus data width; fixed at 32.
- wb_clk_i  in  1  single clock for the bus and both macro clocks (clk0/clk1 driven from it at top level).
- rst_n  in  1  reset, asynchronous assert, active-low.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe and write enable.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid only while wb_ack_o=1.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error (SRAM_WB_ERR_EN only; otherwise constant 0).
- sram_csb0_o, sram_web0_o  out  1  macro chip select / write enable, both active-low.
- sram_wmask0_o  out  4  macro byte mask.
- sram_addr0_o  out  ADDR_WIDTH  macro word address = wb_adr_i[ADDR_WIDTH+1:2].
- sram_din0_o  out  32  macro write data.
- sram_dout0_i  in  32  macro read data.
- sram_csb1_o  out  1  constant 1. sram_addr1_o  out  ADDR_WIDTH  constant 0.

## Operation
- All outputs are registered. Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din0=0, csb1=1, addr1=0, ack=0, err=0, dat_o=0; FSM in IDLE.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_CAPT, DONE.
- In IDLE, a request is cyc&stb&!ack. On the sampling edge P0 the block loads the address, data and mask, and drives csb0=0 and web0=!we_i.
  - For a write, wmask0 = sel_i.
  - For a read, wmask0 = 0 and sel_i is ignored.
- Write: WR_ISSUE holds the pins until P1, when the macro latches them. At P1 the block drives csb0=1, web0=1 and ack=1 for one cycle, then enters DONE.
- Read: RD_ISSUE lasts until P1, when the macro latches the pins and the block releases csb0. The macro drives dout0 after the negedge following P1. RD_WAIT lasts until P2; at P2 sram_dout0_i is registered into dat_o and ack=1 for one cycle. RD_CAPT is a label for the P2 capture.
- Write with sel_i=0: no macro cycle; ack at P0+1.
- DONE lasts one cycle with ack=0, then returns to IDLE. A request seen while ack=1 is ignored, which guarantees the master has dropped stb.
- Abort: if cyc_i drops after P0, the macro access still completes. No ack or err is issued, and the FSM returns to IDLE through DONE.
- Reset mid-operation: the async assert forces the reset values immediately, including csb0=1. An in-flight macro write can still commit on that negedge; this is accepted and not guarded against.

## Timing
- Write latency: ack in the cycle after P1, i.e. 2 cycles from request.
- Read latency: ack in the cycle after P2, i.e. 3 cycles from request.
- Error latency: 1 cycle from request.
- Minimum spacing between requests is one idle cycle after ack, so peak throughput is one read per 4 cycles or one write per 3 cycles.
- sram_dout0_i is sampled only at P2. Its value at any other time (X from the macro) must never reach wb_dat_o.

## Configuration
- SRAM_WB_ERR_EN defined: the block decodes the full wb_adr_i against BASE_ADDR and the window size. A request outside the window gets no macro cycle, err=1 for one cycle at P0+1 and ack=0, then DONE.
- SRAM_WB_ERR_EN undefined: the upper address bits are ignored and all accesses alias into the window; wb_err_o is tied 0.

## Structure
- Package sram_wb_pkg holds:
  - the FSM state enum;
  - WORD_LSB=2;
  - NUM_WMASKS=4;
  - the 1 KiB window-size constant.
- One sub-module, sram_wb_decode, performs window hit and word-address extraction combinationally. It is instantiated unconditionally; its hit output is used only under SRAM_WB_ERR_EN.

## Test plan
- Write 0xDEADBEEF, sel=4'hF, to BASE+0x10, then read BASE+0x10 -> write ack at 2 cycles, read ack at 3 cycles, dat_o=0xDEADBEEF, addr0=4.
- Write 0xAABBCCDD with sel=4'b0101 over existing 0x11223344 -> readback 0x11BB33DD.
- Write with sel=0 -> ack after 1 cycle, csb0 never low, memory unchanged.
- Read with cyc dropped one cycle after P0 -> no ack or err, FSM back in IDLE within 4 cycles, next read returns correct data.
- With SRAM_WB_ERR_EN, read BASE+0x400 -> err=1 after 1 cycle, csb0 stays 1. Without it -> aliases to word 0 with normal ack.
- Assert rst_n low while a read is in RD_WAIT -> csb0=1, ack=0, dat_o=0 immediately. After release, a read returns stored data.

Source files
------------

// File: rtl/sram_wb_pkg.sv
// Shared constants and FSM state type for the Wishbone-to-OpenRAM bridge.
package sram_wb_pkg;

    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned NUM_WMASKS = 4;
    localparam int unsigned WIN_BYTES  = 1024;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPT,
        DONE
    } state_t;

endpackage

// File: rtl/sram_wb_decode.sv
// Combinational window-hit check and word-address extraction for the bridge.
module sram_wb_decode
    import sram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic [31:0]           adr,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] word_addr
);

    localparam int unsigned TOP_LSB = ADDR_WIDTH + WORD_LSB;

    logic unused_byte_lsb;

    assign word_addr       = adr[TOP_LSB-1:WORD_LSB];
    assign hit             = (adr[31:TOP_LSB] == BASE_ADDR[31:TOP_LSB]);
    assign unused_byte_lsb = ^adr[WORD_LSB-1:0];

endmodule

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave driving port 0 of a 32x256 1RW1R OpenRAM macro.
// Define SRAM_WB_ERR_EN to decode the full address and return err outside the window.
module sram_wb_bridge
    import sram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [NUM_WMASKS-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i,
    output logic                  sram_csb1_o,
    output logic [ADDR_WIDTH-1:0] sram_addr1_o
);

    state_t                  state;
    logic                    aborted;
    logic                    err_q;
    logic                    dec_hit;
    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic                    req_c;
    logic                    live_c;
    logic                    in_win_c;

    sram_wb_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .adr       (wb_adr_i),
        .hit       (dec_hit),
        .word_addr (dec_addr)
    );

`ifdef SRAM_WB_ERR_EN
    assign in_win_c = dec_hit;
`else
    logic unused_hit;
    assign unused_hit = dec_hit;
    assign in_win_c   = 1'b1;
`endif

    // Requests are ignored during the ack cycle so a held stb cannot retrigger.
    assign req_c  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign live_c = wb_cyc_i & ~aborted;

    assign wb_err_o     = err_q;
    assign sram_csb1_o  = 1'b1;
    assign sram_addr1_o = '0;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            aborted       <= 1'b0;
            err_q         <= 1'b0;
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= '0;
            sram_addr0_o  <= '0;
            sram_din0_o   <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            err_q    <= 1'b0;
            // A dropped cycle lets the macro access finish but suppresses the response.
            if (state != IDLE && !wb_cyc_i) begin
                aborted <= 1'b1;
            end
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    if (req_c) begin
                        if (!in_win_c) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (wb_we_i && wb_sel_i == '0) begin
                            wb_ack_o <= 1'b1;
                            state    <= DONE;
                        end else begin
                            sram_csb0_o   <= 1'b0;
                            sram_web0_o   <= ~wb_we_i;
                            sram_wmask0_o <= wb_we_i ? wb_sel_i : '0;
                            sram_addr0_o  <= dec_addr;
                            sram_din0_o   <= wb_dat_i;
                            state         <= wb_we_i ? WR_ISSUE : RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    sram_csb0_o <= 1'b1;
                    sram_web0_o <= 1'b1;
                    wb_ack_o    <= live_c;
                    state       <= DONE;
                end
                RD_ISSUE: begin
                    sram_csb0_o <= 1'b1;
                    state       <= RD_WAIT;
                end
                RD_WAIT: begin
                    // dout0 is valid only here, one negedge after the macro latched the read.
                    if (live_c) begin
                        wb_dat_o <= sram_dout0_i;
                        wb_ack_o <= 1'b1;
                    end
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
